pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
//
// PURPOSE
// - Parametrised WIDTH-bit adder/subtractor built from 1-bit full-adder cells, carry chain cut into
//   STAGES pipeline segments so wide operands close timing at one full-adder chunk per cycle.
// - Successor to the single-bit full adder: adds width, subtract mode, signed/unsigned flags,
//   valid/ready flow control and back-pressure. Sits between operand registers and ALU result mux.
//
// PARAMETERS
// - WIDTH   32  operand/result width in bits; must be a multiple of STAGES
// - STAGES   4  pipeline segments; each adds CHUNK = WIDTH/STAGES bits; STAGES=1 gives 1-cycle adder
//
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - reset      in   1      synchronous, active-high
// - in_valid   in   1      operand beat present
// - in_ready   out  1      block accepts operand beat this cycle
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - sub        in   1      0: a+b, 1: a-b (a + ~b + 1)
// - out_valid  out  1      result beat present
// - out_ready  in   1      consumer accepts result this cycle
// - sum        out  WIDTH  result, mod 2^WIDTH
// - carryout   out  1      carry out of MSB (sub: 1 = no borrow)
// - overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
// - zero       out  1      sum == 0
//
// BEHAVIOUR
// - Reset: all stage valid bits 0; out_valid=0, sum=0, carryout=0, overflow=0, zero=0; in_ready=1 the
//   cycle after reset deasserts. Reset mid-operation flushes every in-flight beat; none emerge later.
// - Accept: beat captured when in_valid && in_ready. Fire: result consumed when out_valid && out_ready.
// - Advance enable adv = !out_valid || out_ready; in_ready = adv (combinational). Whole pipe moves
//   together; when adv=0 every stage register, including outputs, holds its value.
// - Latency: exactly STAGES cycles accept->out_valid with out_ready held 1; throughput 1 beat/cycle.
// - Stage 0: b_eff = sub ? ~b : b; carry-in = sub. Stage k adds chunk k of a, b_eff plus registered
//   carry from stage k-1; upper unprocessed chunks and finished lower sum chunks travel along with
//   their valid bit and sub flag (operand skew). Final stage registers sum, carryout, overflow, zero.
// - Bubbles (stage valid=0) still advance when adv=1; their data is don't-care, but sum/flags outputs
//   change only on a valid final-stage load.
// - out_valid and outputs stable while out_valid && !out_ready (no drop, no duplicate).
// - Simultaneous accept and fire in one cycle: both occur; pipe holds at most STAGES beats.
// - Arithmetic identical to WIDTH chained full adders: sum = a ± b mod 2^WIDTH; zero from final sum.
// - No X on outputs after reset regardless of a/b/sub when in_valid=0.
//
// STRUCTURE
// - Shared header/package: ADD/SUB mode encodings (MODE_ADD=0, MODE_SUB=1) and flag bit indices
//   {overflow,carryout,zero} reused by the ALU result mux.
// - One sub-module: add_chunk #(CHUNK) — combinational CHUNK-bit ripple of structural full-adder
//   cells, ports (a, b, cin) -> (s, cout, c_msb_in); instantiated once per stage via generate.
// - Top owns stage registers, valid chain, adv logic and final flag registers.
//
// TESTING (WIDTH=8, STAGES=2 unless noted; out_ready=1 unless noted)
// - Add overflow: a=0x7F b=0x01 sub=0 -> after 2 cycles sum=0x80 carryout=0 overflow=1 zero=0.
// - Wrap: a=0xFF b=0x01 sub=0 -> sum=0x00 carryout=1 overflow=0 zero=1.
// - Subtract: a=0x05 b=0x07 sub=1 -> sum=0xFE carryout=0 overflow=0; a=0x80 b=0x01 sub=1 -> sum=0x7F
//   carryout=1 overflow=1.
// - Back-pressure: stream 4 beats (1+1,2+2,3+3,4+4), out_ready=0 for 3 cycles after first out_valid
//   -> in_ready=0 while stalled; results 2,4,6,8 in order, no loss or duplicate, sum held while stalled.
// - Reset mid-flight: accept 2 beats, assert reset 1 cycle -> out_valid stays 0, no result emerges,
//   all outputs 0; next accepted beat appears after exactly STAGES cycles.
// - Exhaustive sweep WIDTH=4 STAGES in {1,2,4}: all a,b,sub back-to-back -> each result matches
//   {carryout,sum} = a + (sub ? ~b+1 : b) reference model, 1 beat/cycle.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// Shared encodings for the pipelined adder/subtractor and the ALU result mux that consumes its flags.
// Also holds the offset helpers for the packed stage-boundary registers.
package pipelined_add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_W     = 3;

  typedef struct packed {
    logic overflow;
    logic carryout;
    logic zero;
  } flags_t;

  // Boundary j (after stage j) keeps (stages-1-j) unprocessed operand chunks;
  // all boundaries are packed back to back into one vector.
  function automatic int rem_off(input int j, input int stages, input int chunk);
    return chunk * (j * (stages - 1) - (j * (j - 1)) / 2);
  endfunction

  // Boundary j keeps the (j+1) finished low sum chunks.
  function automatic int done_off(input int j, input int chunk);
    return chunk * ((j * (j + 1)) / 2);
  endfunction

  function automatic int tri_bits(input int stages, input int chunk);
    return (stages > 1) ? chunk * (((stages - 1) * stages) / 2) : 1;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder made of 1-bit full-adder cells.
// c_msb_in_o is the carry into the top bit, used for signed overflow.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);
  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa_cell u_fa (
      .a_i(a_i[i]),
      .b_i(b_i[i]),
      .c_i(c[i]),
      .s_o(s_o[i]),
      .c_o(c[i+1])
    );
  end

  assign cout_o     = c[CHUNK];
  assign c_msb_in_o = c[CHUNK-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract with the carry chain split into STAGES registered segments.
// Operands are skewed through the pipe: each stage consumes its chunk and passes the rest along.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int TRI   = tri_bits(STAGES, CHUNK);
  localparam int NB    = (STAGES > 1) ? STAGES - 1 : 1;

  // Handshake: a beat is accepted when in_valid && in_ready and a result is consumed when
  // out_valid && out_ready; the whole pipe advances together whenever the output slot is free
  // or being drained, so in_ready is that same advance enable.
  logic adv;

  logic [NB-1:0]    valid_q;
  logic [NB-1:0]    carry_q;
  logic [TRI-1:0]   a_rem_q;
  logic [TRI-1:0]   b_rem_q;
  logic [TRI-1:0]   done_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  flags_t           flags_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = (STAGES - k) * CHUNK;

    logic [RW-1:0]          a_in;
    logic [RW-1:0]          b_in;
    logic                   c_in;
    logic                   v_in;
    logic [CHUNK-1:0]       s;
    logic                   cout;
    logic                   cmsb;
    logic [(k+1)*CHUNK-1:0] acc;

    if (k == 0) begin : g_first
      assign a_in = a;
      assign b_in = (sub == MODE_SUB) ? ~b : b;
      assign c_in = sub;
      assign v_in = in_valid;
      assign acc  = s;
    end else begin : g_next
      localparam int IN_ROFF = rem_off(k - 1, STAGES, CHUNK);
      localparam int IN_DOFF = done_off(k - 1, CHUNK);
      assign a_in = a_rem_q[IN_ROFF +: RW];
      assign b_in = b_rem_q[IN_ROFF +: RW];
      assign c_in = carry_q[k-1];
      assign v_in = valid_q[k-1];
      assign acc  = {s, done_q[IN_DOFF +: k*CHUNK]};
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i       (a_in[CHUNK-1:0]),
      .b_i       (b_in[CHUNK-1:0]),
      .cin_i     (c_in),
      .s_o       (s),
      .cout_o    (cout),
      .c_msb_in_o(cmsb)
    );

    if (k < STAGES - 1) begin : g_reg
      localparam int OUT_ROFF = rem_off(k, STAGES, CHUNK);
      localparam int OUT_DOFF = done_off(k, CHUNK);
      logic cmsb_unused;
      assign cmsb_unused = cmsb;

      // Data registers need no reset: they are only observed behind a set valid bit.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q[k] <= 1'b0;
        end else if (adv) begin
          valid_q[k] <= v_in;
        end
        if (adv) begin
          a_rem_q[OUT_ROFF +: RW-CHUNK]    <= a_in[RW-1:CHUNK];
          b_rem_q[OUT_ROFF +: RW-CHUNK]    <= b_in[RW-1:CHUNK];
          carry_q[k]                       <= cout;
          done_q[OUT_DOFF +: (k+1)*CHUNK]  <= acc;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          flags_q     <= '0;
        end else if (adv) begin
          out_valid_q <= v_in;
          if (v_in) begin
            sum_q            <= acc;
            flags_q.carryout <= cout;
            flags_q.overflow <= cout ^ cmsb;
            flags_q.zero     <= (acc == '0);
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carryout  = flags_q.carryout;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: an 8-bit/2-stage instance for the directed and streaming scenarios,
// plus three 4-bit instances (1, 2 and 4 stages) for the exhaustive sweep.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 8-bit, 2-stage instance
  logic       m_in_valid, m_in_ready, m_sub, m_out_valid, m_out_ready;
  logic [7:0] m_a, m_b, m_sum;
  logic       m_cout, m_ovf, m_zero;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .carryout(m_cout), .overflow(m_ovf), .zero(m_zero)
  );

  // 4-bit sweep instances share one input stream
  logic       s_in_valid, s_sub, s_out_ready;
  logic [3:0] s_a, s_b;
  logic [2:0] sw_in_ready, sw_out_valid, sw_cout, sw_ovf, sw_zero;
  logic [3:0] sw_sum [3];

  pipelined_add_sub #(.WIDTH(4), .STAGES(1)) u_sw1 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(sw_in_ready[0]),
    .a(s_a), .b(s_b), .sub(s_sub),
    .out_valid(sw_out_valid[0]), .out_ready(s_out_ready),
    .sum(sw_sum[0]), .carryout(sw_cout[0]), .overflow(sw_ovf[0]), .zero(sw_zero[0])
  );
  pipelined_add_sub #(.WIDTH(4), .STAGES(2)) u_sw2 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(sw_in_ready[1]),
    .a(s_a), .b(s_b), .sub(s_sub),
    .out_valid(sw_out_valid[1]), .out_ready(s_out_ready),
    .sum(sw_sum[1]), .carryout(sw_cout[1]), .overflow(sw_ovf[1]), .zero(sw_zero[1])
  );
  pipelined_add_sub #(.WIDTH(4), .STAGES(4)) u_sw4 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(sw_in_ready[2]),
    .a(s_a), .b(s_b), .sub(s_sub),
    .out_valid(sw_out_valid[2]), .out_ready(s_out_ready),
    .sum(sw_sum[2]), .carryout(sw_cout[2]), .overflow(sw_ovf[2]), .zero(sw_zero[2])
  );

  int n_cmp = 0;
  int n_fail = 0;

  // expected {overflow, carryout, zero, sum}
  logic [10:0] exp_q[$];
  // expected {overflow, zero, carryout, sum} for the 4-bit sweep
  logic [6:0]  sw_exp[$];

  function automatic logic [10:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] be;
    logic [8:0] full;
    logic       ov;
    be   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, be} + {8'd0, s};
    ov   = (x[7] == be[7]) && (full[7] != x[7]);
    return {ov, full[8], (full[7:0] == 8'd0), full[7:0]};
  endfunction

  // Called just after a falling edge: drive one cycle, retire a firing result, record an accept.
  task automatic sb_step(input logic iv, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xs, input logic xr, input logic [10:0] xexp,
                         output logic acc);
    logic [10:0] got, e;
    m_in_valid  = iv;
    m_a         = xa;
    m_b         = xb;
    m_sub       = xs;
    m_out_ready = xr;
    #1;
    if (m_out_valid && m_out_ready) begin
      n_cmp++;
      got = {m_ovf, m_cout, m_zero, m_sum};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h, required no result", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL result {ovf,cout,zero,sum}: got %h required %h", got, e);
        end
      end
    end
    acc = iv && m_in_ready;
    if (acc) exp_q.push_back(xexp);
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      sb_step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 11'd0, acc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d outstanding, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_a = '0; m_b = '0; m_sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_sub = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", m_out_valid); end
    n_cmp++;
    if (m_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h required 00", m_sum); end
    n_cmp++;
    if ({m_cout, m_ovf, m_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {m_cout, m_ovf, m_zero});
    end
    n_cmp++;
    if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", m_in_ready); end
    n_cmp++;
    if (sw_out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_sweep_valid: got %b required 000", sw_out_valid); end
  endtask

  task automatic test_arith();
    logic [7:0]  va[3];
    logic [7:0]  vb[3];
    logic        vs[3];
    logic [10:0] ve[3];
    logic        acc, seen;
    int          lat;
    va = '{8'hFF, 8'h05, 8'h80};
    vb = '{8'h01, 8'h07, 8'h01};
    vs = '{1'b0, 1'b1, 1'b1};
    ve = '{{3'b011, 8'h00}, {3'b000, 8'hFE}, {3'b110, 8'h7F}};
    @(negedge clk);
    sb_step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, {3'b100, 8'h80}, acc);
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      sb_step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 11'd0, acc);
      lat++;
      if (m_out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || lat != 2) begin n_fail++; $display("FAIL latency: got %0d cycles required 2", lat); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      sb_step(1'b1, va[j], vb[j], vs[j], 1'b1, ve[j], acc);
      n_cmp++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL arith_accept: got %b required 1", acc); end
    end
    drain("arith");
  endtask

  task automatic test_back_pressure();
    int   i;
    int   stall;
    logic acc, orv;
    i = 0; stall = -1;
    for (int c = 0; c < 40 && (i < 4 || exp_q.size() > 0); c++) begin
      @(negedge clk);
      if (stall < 0 && m_out_valid) stall = 3;
      orv = !(stall > 0);
      sb_step(i < 4, 8'(i + 1), 8'(i + 1), 1'b0, orv, {3'b000, 8'(2 * (i + 1))}, acc);
      if (stall > 0) begin
        n_cmp++;
        if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b required 0", m_in_ready); end
        n_cmp++;
        if (m_out_valid !== 1'b1 || m_sum !== 8'd2) begin
          n_fail++; $display("FAIL stall_hold: got valid %b sum %h required 1 02", m_out_valid, m_sum);
        end
        stall--;
      end
      if (acc) i++;
    end
    n_cmp++;
    if (i != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_complete: got %0d sent %0d left, required 4 sent 0 left", i, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic acc, seen;
    int   lat;
    @(negedge clk);
    sb_step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, model8(8'h11, 8'h22, 1'b0), acc);
    @(negedge clk);
    sb_step(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, model8(8'h33, 8'h44, 1'b1), acc);
    @(negedge clk);
    reset = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b required 0", m_out_valid); end
    n_cmp++;
    if ({m_ovf, m_cout, m_zero, m_sum} !== 11'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h required 000", {m_ovf, m_cout, m_zero, m_sum});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sb_step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 11'd0, acc);
      n_cmp++;
      if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emerge: got valid %b required 0", m_out_valid); end
    end
    @(negedge clk);
    sb_step(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, {3'b000, 8'h30}, acc);
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      sb_step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 11'd0, acc);
      lat++;
      if (m_out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || lat != 2) begin n_fail++; $display("FAIL post_reset_latency: got %0d cycles required 2", lat); end
    drain("reset_mid");
  endtask

  task automatic test_random();
    logic       acc, iv, xr, xs;
    logic [7:0] xa, xb;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      iv = ($urandom_range(0, 3) != 0);
      xr = ($urandom_range(0, 3) != 0);
      xa = 8'($urandom_range(0, 255));
      xb = 8'($urandom_range(0, 255));
      xs = 1'($urandom_range(0, 1));
      sb_step(iv, xa, xb, xs, xr, model8(xa, xb, xs), acc);
    end
    drain("random");
  endtask

  task automatic test_sweep();
    int         idx[3];
    logic [8:0] v;
    logic [3:0] be;
    logic [4:0] r;
    logic       ov;
    logic [6:0] got;
    idx = '{0, 0, 0};
    sw_exp.delete();
    s_out_ready = 1'b1;
    for (int c = 0; c < 530; c++) begin
      @(negedge clk);
      v = c[8:0];
      s_in_valid = (c < 512);
      s_sub = v[8]; s_a = v[7:4]; s_b = v[3:0];
      #1;
      for (int d = 0; d < 3; d++) begin
        if (sw_out_valid[d]) begin
          n_cmp++;
          got = {sw_ovf[d], sw_zero[d], sw_cout[d], sw_sum[d]};
          if (idx[d] >= sw_exp.size()) begin
            n_fail++; $display("FAIL sweep_extra dut%0d: got %h required no result", d, got);
          end else begin
            if (got !== sw_exp[idx[d]]) begin
              n_fail++;
              $display("FAIL sweep dut%0d beat %0d {ovf,zero,cout,sum}: got %h required %h", d, idx[d], got, sw_exp[idx[d]]);
            end
            idx[d]++;
          end
        end
      end
      if (s_in_valid) begin
        n_cmp++;
        if (sw_in_ready !== 3'b111) begin n_fail++; $display("FAIL sweep_in_ready: got %b required 111", sw_in_ready); end
        be = s_sub ? ~s_b : s_b;
        r  = {1'b0, s_a} + (s_sub ? ({1'b0, ~s_b} + 5'd1) : {1'b0, s_b});
        ov = (s_a[3] == be[3]) && (r[3] != s_a[3]);
        sw_exp.push_back({ov, (r[3:0] == 4'd0), r});
      end
    end
    s_in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (idx[d] != 512) begin n_fail++; $display("FAIL sweep_count dut%0d: got %0d required 512", d, idx[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_pressure();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
